// File: rtl/flex_cnt_pkg.sv
// Shared definitions for the cascaded flex counter (optional FLEX_CNT_LOAD_EN adds a parallel load).
// Holds default sizing, packed-slice indexing and the per-channel next-state case encoding.
package flex_cnt_pkg;

    localparam int DEF_CNT_BITS = 4;
    localparam int DEF_NUM_CH   = 3;

    // Which rule decided a channel's next state; LOAD only occurs when FLEX_CNT_LOAD_EN is defined.
    typedef enum logic [2:0] {
        CLR    = 3'd0,
        DIS    = 3'd1,
        HOLD   = 3'd2,
        WRAP   = 3'd3,
        RELOAD = 3'd4,
        INC    = 3'd5,
        LOAD   = 3'd6
    } next_case_e;

    function automatic int slice_lsb(input int ch, input int width);
        return ch * width;
    endfunction

endpackage

// File: rtl/flex_cnt_stage.sv
// One channel of the cascaded counter: counts 1..rv, flags the terminal value and reports its wrap.
// FLEX_CNT_LOAD_EN adds load/load_value ports that preload the count.
module flex_cnt_stage
    import flex_cnt_pkg::*;
#(
    parameter int W = DEF_CNT_BITS
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         en,
    input  logic         clear,
    input  logic [W-1:0] rv,
`ifdef FLEX_CNT_LOAD_EN
    input  logic         load,
    input  logic [W-1:0] load_value,
`endif
    output logic [W-1:0] count,
    output logic         flag,
    output logic         wrap
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] count_q, count_d;
    logic         flag_q, flag_d;
    logic         rv_zero;
    logic         load_now;
    next_case_e   ns_sel;

    assign rv_zero = (rv == '0);

`ifdef FLEX_CNT_LOAD_EN
    assign load_now = load;
`else
    assign load_now = 1'b0;
`endif

    // Wrap also covers the reload when the count already sits at/above a lowered rv.
    assign wrap = en && !load_now && !rv_zero && (flag_q || (count_q >= rv));

    always_comb begin
        ns_sel = HOLD;
        if (clear)                ns_sel = CLR;
        else if (load_now)        ns_sel = LOAD;
        else if (rv_zero)         ns_sel = DIS;
        else if (!en)             ns_sel = HOLD;
        else if (flag_q)          ns_sel = WRAP;
        else if (count_q >= rv)   ns_sel = RELOAD;
        else                      ns_sel = INC;
    end

    always_comb begin
        count_d = count_q;
        flag_d  = flag_q;
        case (ns_sel)
            CLR: begin
                count_d = ONE;
                flag_d  = 1'b0;
            end
`ifdef FLEX_CNT_LOAD_EN
            LOAD: begin
                count_d = load_value;
                flag_d  = (load_value == rv) && !rv_zero;
            end
`endif
            DIS: begin
                flag_d = 1'b0;
            end
            WRAP, RELOAD: begin
                count_d = ONE;
                flag_d  = (rv == ONE);
            end
            INC: begin
                count_d = count_q + ONE;
                flag_d  = ((count_q + ONE) == rv);
            end
            default: begin
                count_d = count_q;
                flag_d  = flag_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
            flag_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            flag_q  <= flag_d;
        end
    end

    assign count = count_q;
    assign flag  = flag_q;

endmodule

// File: rtl/flex_counter_cascade.sv
// Odometer-style chain of flex_cnt_stage channels; channel i advances when channel i-1 wraps.
// FLEX_CNT_LOAD_EN adds a parallel load of all channels.
module flex_counter_cascade
    import flex_cnt_pkg::*;
#(
    parameter int NUM_CNT_BITS = DEF_CNT_BITS,
    parameter int NUM_CH       = DEF_NUM_CH
) (
    input  logic                         clk,
    input  logic                         n_rst,
    input  logic                         count_enable,
    input  logic                         clear,
    input  logic [NUM_CH*NUM_CNT_BITS-1:0] rollover_value,
`ifdef FLEX_CNT_LOAD_EN
    input  logic                         load,
    input  logic [NUM_CH*NUM_CNT_BITS-1:0] load_value,
`endif
    output logic [NUM_CH*NUM_CNT_BITS-1:0] count_out,
    output logic [NUM_CH-1:0]            rollover_flag,
    output logic                         carry_out,
    output logic                         all_rollover
);

    logic [NUM_CH-1:0] en;
    logic [NUM_CH-1:0] wrap;

    // The enable chain is purely combinational, so every channel updates on the same edge.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        localparam int LSB = slice_lsb(gi, NUM_CNT_BITS);

        if (gi == 0) begin : g_first
            assign en[gi] = count_enable;
        end else begin : g_next
            assign en[gi] = wrap[gi-1];
        end

        flex_cnt_stage #(
            .W(NUM_CNT_BITS)
        ) u_stage (
            .clk        (clk),
            .n_rst      (n_rst),
            .en         (en[gi]),
            .clear      (clear),
            .rv         (rollover_value[LSB +: NUM_CNT_BITS]),
`ifdef FLEX_CNT_LOAD_EN
            .load       (load),
            .load_value (load_value[LSB +: NUM_CNT_BITS]),
`endif
            .count      (count_out[LSB +: NUM_CNT_BITS]),
            .flag       (rollover_flag[gi]),
            .wrap       (wrap[gi])
        );
    end

    assign carry_out    = wrap[NUM_CH-1];
    assign all_rollover = &rollover_flag;

endmodule

// File: tb/tb_flex_counter_cascade.sv
// Directed self-checking bench for flex_counter_cascade (W=4, 3 channels); load checks run when FLEX_CNT_LOAD_EN is defined.
module tb_flex_counter_cascade;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        count_enable;
    logic        clear;
    logic [11:0] rollover_value;
    logic [11:0] count_out;
    logic [2:0]  rollover_flag;
    logic        carry_out;
    logic        all_rollover;
`ifdef FLEX_CNT_LOAD_EN
    logic        load = 1'b0;
    logic [11:0] load_value = '0;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    int n_carry;
    int n_all;
    int first_carry;

    flex_counter_cascade #(.NUM_CNT_BITS(4), .NUM_CH(3)) dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .count_enable   (count_enable),
        .clear          (clear),
        .rollover_value (rollover_value),
`ifdef FLEX_CNT_LOAD_EN
        .load           (load),
        .load_value     (load_value),
`endif
        .count_out      (count_out),
        .rollover_flag  (rollover_flag),
        .carry_out      (carry_out),
        .all_rollover   (all_rollover)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
        $display("check %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    initial begin
        n_rst          = 1'b1;
        count_enable   = 1'b0;
        clear          = 1'b0;
        rollover_value = 12'h234;
        #2 n_rst = 1'b0;
        tick();
        tick();
        check("reset_count", 32'(count_out), 32'h000);
        check("reset_flag", 32'(rollover_flag), 32'h0);
        check("reset_all", 32'(all_rollover), 32'h0);

        // Release mid-cycle with enable held; channel periods 4, 12, 24.
        n_rst        = 1'b1;
        count_enable = 1'b1;
        n_carry      = 0;
        n_all        = 0;
        first_carry  = 0;
        for (int n = 1; n <= 64; n++) begin
            tick();
            if (carry_out) begin
                n_carry++;
                if (first_carry == 0) first_carry = n;
            end
            if (all_rollover) n_all++;
            case (n)
                1:  check("first_edge", 32'(count_out), 32'h001);
                4:  begin
                        check("e4_count", 32'(count_out), 32'h004);
                        check("e4_flag", 32'(rollover_flag), 32'h1);
                    end
                6:  check("e6_count", 32'(count_out), 32'h012);
                17: check("e17_count", 32'(count_out), 32'h111);
                40: begin
                        check("e40_count", 32'(count_out), 32'h234);
                        check("e40_all", 32'(all_rollover), 32'h1);
                    end
                41: check("e41_count", 32'(count_out), 32'h111);
                64: check("e64_count", 32'(count_out), 32'h234);
                default: ;
            endcase
        end
        check("carry_cycles", 32'(n_carry), 32'd2);
        check("first_carry", 32'(first_carry), 32'd40);
        check("all_cycles", 32'(n_all), 32'd2);

        // Clear with enable while every flag is set: carry still reflects pre-edge flags.
        clear = 1'b1;
        #1;
        check("clr_carry_pre", 32'(carry_out), 32'h1);
        tick();
        check("clr_count", 32'(count_out), 32'h111);
        check("clr_flag", 32'(rollover_flag), 32'h0);
        check("clr_all", 32'(all_rollover), 32'h0);
        clear = 1'b0;

        // Count channel 0 to 7 against rv 10, then lower rv to 5.
        rollover_value = 12'h23A;
        for (int n = 0; n < 6; n++) tick();
        check("rv10_count", 32'(count_out), 32'h117);
        count_enable   = 1'b0;
        rollover_value = 12'h235;
        tick();
        check("rv5_hold", 32'(count_out), 32'h117);
        count_enable = 1'b1;
        tick();
        check("rv5_reload", 32'(count_out), 32'h121);
        check("rv5_flag", 32'(rollover_flag), 32'h0);

        // Channel 1 disabled, channel 0 rv=1 wraps every enable.
        rollover_value = 12'h201;
        for (int n = 0; n < 6; n++) begin
            tick();
            check("dis_count", 32'(count_out), 32'h121);
            check("dis_flag", 32'(rollover_flag), 32'h1);
            check("dis_carry", 32'(carry_out), 32'h0);
        end

        // Asynchronous reset mid-cycle.
        #3 n_rst = 1'b0;
        #1;
        check("async_count", 32'(count_out), 32'h000);
        check("async_flag", 32'(rollover_flag), 32'h0);
        tick();
        check("rst_hold", 32'(count_out), 32'h000);
        n_rst = 1'b1;
        tick();
        check("post_rst_count", 32'(count_out), 32'h001);
        check("post_rst_flag", 32'(rollover_flag), 32'h1);

`ifdef FLEX_CNT_LOAD_EN
        rollover_value = 12'h351;
        load_value     = 12'h321;
        load           = 1'b1;
        #1;
        check("load_carry", 32'(carry_out), 32'h0);
        tick();
        check("load_count", 32'(count_out), 32'h321);
        check("load_flag", 32'(rollover_flag), 32'h5);
        load = 1'b0;
        tick();
        check("after_load_count", 32'(count_out), 32'h331);
        check("after_load_flag", 32'(rollover_flag), 32'h5);
        check("after_load_carry", 32'(carry_out), 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/flex_counter_cascade.md
Name: flex_counter_cascade

Overview:
- Parametrised successor of the single-channel flex counter: NUM_CH counters of NUM_CNT_BITS each, chained odometer-style.
- Each channel increments only when the channel below it wraps.
- Serves the USB TX path as a single bit-timer → bit-count → byte-count chain, replacing separately wired counters.
- Adds per-channel rollover values, carry chaining, a global terminal indication and robust handling of rollover-value changes.

Parameters:
- NUM_CNT_BITS, 4, width of each channel's count.
- NUM_CH, 3, number of cascaded channels (≥1); channel 0 is least significant.

Ports:
- clk  in  1  system clock.
- n_rst  in  1  asynchronous active-low reset.
- count_enable  in  1  advance request to channel 0.
- clear  in  1  synchronous clear of all channels.
- rollover_value  in  NUM_CH*NUM_CNT_BITS  packed per-channel terminal values; channel i occupies bits [i*W +: W].
- count_out  out  NUM_CH*NUM_CNT_BITS  packed per-channel counts, same packing.
- rollover_flag  out  NUM_CH  per-channel registered flag, high while that channel sits at its terminal value.
- carry_out  out  1  combinational; high in the cycle channel NUM_CH-1 wraps.
- all_rollover  out  1  combinational AND of all rollover_flag bits.

Behaviour:
- Reset (n_rst low, async): every count_out channel = 0, every rollover_flag = 0. Outputs are valid from the first clock after release.
- Enables:
  - en[0] = count_enable.
  - wrap[i] = en[i] && rollover_flag[i].
  - en[i+1] = wrap[i].
  - carry_out = wrap[NUM_CH-1].
  - All enables are combinational, so the whole chain updates on the same edge: zero-cycle ripple.
- Per-channel next state, in priority order:
  1. clear: count = 1, flag = 0, for every channel regardless of enable.
  2. rv == 0: channel is disabled. Count holds, flag is forced to 0, wrap is 0.
  3. !en: hold count and flag.
  4. en && flag: count = 1, flag = (rv == 1). This is a wrap.
  5. en && !flag && count >= rv: count = 1, flag = (rv == 1). This is a wrap-equivalent reload and also asserts wrap[i]. It covers a rollover_value lowered mid-count and clear followed by rv = 1.
  6. en && !flag: count = count + 1 in W bits, flag = (count + 1 == rv).
- The sequence per channel with rv = N is 1, 2, …, N (flag high at N), then 1 again. The first pass after reset starts from 0.
- All comparisons are unsigned, W bits wide. There is no overflow past 2^W − 1, because of rule 5.
- clear and count_enable in the same cycle: clear wins, and carry_out is still computed from pre-edge flags. Consumers must ignore carry_out while clear is high.
- rollover_value is sampled every cycle and has no latch. Changes take effect on the next enabled edge.

Optional Feature:
- Macro FLEX_CNT_LOAD_EN.
- Enabled: adds ports load (in, 1) and load_value (in, NUM_CH*NUM_CNT_BITS).
  - load sits below clear and above all other rules.
  - Every channel count = its load_value slice, flag = (slice == rv && rv != 0).
  - No wrap is asserted on a load cycle.
- Disabled: the ports are absent and behaviour is exactly as above.

Decomposition:
- Package flex_cnt_pkg holds:
  - default width and channel-count localparams;
  - a function for packed-slice indexing;
  - an enum of the next-state cases (CLR, DIS, HOLD, WRAP, RELOAD, INC) for coverage.
- Sub-module flex_cnt_stage: one channel, with inputs clk, n_rst, en, clear, rv (plus load/load_value under the macro), and outputs count, flag, wrap.
- The top is a generate loop of flex_cnt_stage plus the two reduction outputs.

Test Plan:
- Reset: n_rst low mid-count, async → count_out = 0 and rollover_flag = 0 immediately. After release with enable held, channel 0 reads 1 on the first edge.
- W = 4, NUM_CH = 3, rv = {2,3,4}, enable held:
  - channel 0 cycles 1-2-3-4.
  - channel 1 steps once per channel 0 wrap.
  - carry_out fires once per 24-enable period after the first.
  - all_rollover is high for exactly 1 cycle per period.
- Channel 0 at count 7 with rv = 10; rv changed to 5, then enable → count 1, wrap asserted, channel 1 increments.
- clear and count_enable both high while channel 0 flag = 1 → every count = 1, every flag = 0. Check carry_out and ignore it.
- Channel 1 rv = 0 → channel 1 frozen with flag 0, channel 2 never increments, carry_out never asserts. rv = 1 on channel 0 → flag stays 1 and wraps every enable.
- With FLEX_CNT_LOAD_EN: load with slices {3,2,1} against rv {3,5,1} → flags {1,0,1}, no carry. The next enable wraps channel 0 to 1 and channel 1 to 3.
